id_ex_stage_reg: RTL



---
 rtl/id_ex_stage_reg.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded instruction and operands, detects load-use hazards.
// Latency: one cycle from ID inputs to ex_* outputs; stall_o is combinational in the same cycle.
// Backpressure: stall_o holds PC and IF/ID on a load-use hazard; freeze_i holds every register here.
// Optional feature: define ID_EX_WB_BYPASS_EN to forward same-cycle writeback data into ex_val1/ex_val2.
module id_ex_stage_reg #(
    parameter int WORD_LEN     = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int CMD_LEN      = 4,
    parameter int CNT_LEN      = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    freeze_i,
    input  logic                    flush_i,
    input  logic                    id_valid_i,
    input  logic [WORD_LEN-1:0]     id_pc_i,
    input  logic [WORD_LEN-1:0]     id_reg1_i,
    input  logic [WORD_LEN-1:0]     id_reg2_i,
    input  logic [REG_ADDR_LEN-1:0] id_src1_i,
    input  logic [REG_ADDR_LEN-1:0] id_src2_i,
    input  logic                    id_use_src2_i,
    input  logic [REG_ADDR_LEN-1:0] id_dest_i,
    input  logic [WORD_LEN-1:0]     id_imm_i,
    input  logic [CMD_LEN-1:0]      id_exe_cmd_i,
    input  logic                    id_wb_en_i,
    input  logic                    id_mem_read_i,
    input  logic                    id_mem_write_i,
    input  logic                    id_is_imm_i,
    input  logic                    wb_en_i,
    input  logic [REG_ADDR_LEN-1:0] wb_dest_i,
    input  logic [WORD_LEN-1:0]     wb_val_i,
    output logic                    stall_o,
    output logic                    ex_valid_o,
    output logic [WORD_LEN-1:0]     ex_pc_o,
    output logic [WORD_LEN-1:0]     ex_val1_o,
    output logic [WORD_LEN-1:0]     ex_val2_o,
    output logic [WORD_LEN-1:0]     ex_imm_o,
    output logic [REG_ADDR_LEN-1:0] ex_src1_o,
    output logic [REG_ADDR_LEN-1:0] ex_src2_o,
    output logic [REG_ADDR_LEN-1:0] ex_dest_o,
    output logic [CMD_LEN-1:0]      ex_exe_cmd_o,
    output logic                    ex_wb_en_o,
    output logic                    ex_mem_read_o,
    output logic                    ex_mem_write_o,
    output logic                    ex_is_imm_o,
    output logic [CNT_LEN-1:0]      bubble_cnt_o
);

    logic                    valid_q, valid_d;
    logic [WORD_LEN-1:0]     pc_q, pc_d, val1_q, val1_d, val2_q, val2_d, imm_q, imm_d;
    logic [REG_ADDR_LEN-1:0] src1_q, src1_d, src2_q, src2_d, dest_q, dest_d;
    logic [CMD_LEN-1:0]      cmd_q, cmd_d;
    logic                    wb_en_q, wb_en_d, mem_read_q, mem_read_d;
    logic                    mem_write_q, mem_write_d, is_imm_q, is_imm_d;
    logic [CNT_LEN-1:0]      cnt_q, cnt_d;
    logic                    hazard;
    logic [WORD_LEN-1:0]     val1_sel, val2_sel;

    // A load in EX whose destination is read by the ID instruction; $0 is never a real dependency.
    assign hazard = valid_q & mem_read_q & id_valid_i & (dest_q != '0) &
                    ((dest_q == id_src1_i) | (id_use_src2_i & (dest_q == id_src2_i)));
    assign stall_o = hazard & ~flush_i & rst_i;

`ifdef ID_EX_WB_BYPASS_EN
    assign val1_sel = (wb_en_i && (wb_dest_i != '0) && (wb_dest_i == id_src1_i)) ? wb_val_i : id_reg1_i;
    assign val2_sel = (wb_en_i && (wb_dest_i != '0) && (wb_dest_i == id_src2_i)) ? wb_val_i : id_reg2_i;
`else
    logic wb_unused;
    assign wb_unused = ^{wb_en_i, wb_dest_i, wb_val_i};
    assign val1_sel  = id_reg1_i;
    assign val2_sel  = id_reg2_i;
`endif

    // Next state: freeze holds, flush/hazard load a bubble (only hazards are counted), else capture ID.
    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        val1_d      = val1_q;
        val2_d      = val2_q;
        imm_d       = imm_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        dest_d      = dest_q;
        cmd_d       = cmd_q;
        wb_en_d     = wb_en_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        is_imm_d    = is_imm_q;
        cnt_d       = cnt_q;
        if (freeze_i) begin
            cnt_d = cnt_q;
        end else if (flush_i || hazard) begin
            valid_d     = 1'b0;
            pc_d        = '0;
            val1_d      = '0;
            val2_d      = '0;
            imm_d       = '0;
            src1_d      = '0;
            src2_d      = '0;
            dest_d      = '0;
            cmd_d       = '0;
            wb_en_d     = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            is_imm_d    = 1'b0;
            if (!flush_i && (cnt_q != {CNT_LEN{1'b1}})) begin
                cnt_d = cnt_q + CNT_LEN'(1);
            end
        end else begin
            valid_d     = id_valid_i;
            pc_d        = id_pc_i;
            val1_d      = val1_sel;
            val2_d      = val2_sel;
            imm_d       = id_imm_i;
            src1_d      = id_src1_i;
            src2_d      = id_src2_i;
            dest_d      = id_dest_i;
            cmd_d       = id_exe_cmd_i;
            wb_en_d     = id_valid_i & id_wb_en_i;
            mem_read_d  = id_valid_i & id_mem_read_i;
            mem_write_d = id_valid_i & id_mem_write_i;
            is_imm_d    = id_valid_i & id_is_imm_i;
        end
    end

    // Pipeline state with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            val1_q      <= '0;
            val2_q      <= '0;
            imm_q       <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            dest_q      <= '0;
            cmd_q       <= '0;
            wb_en_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            is_imm_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            val1_q      <= val1_d;
            val2_q      <= val2_d;
            imm_q       <= imm_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            dest_q      <= dest_d;
            cmd_q       <= cmd_d;
            wb_en_q     <= wb_en_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            is_imm_q    <= is_imm_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ex_valid_o     = valid_q;
    assign ex_pc_o        = pc_q;
    assign ex_val1_o      = val1_q;
    assign ex_val2_o      = val2_q;
    assign ex_imm_o       = imm_q;
    assign ex_src1_o      = src1_q;
    assign ex_src2_o      = src2_q;
    assign ex_dest_o      = dest_q;
    assign ex_exe_cmd_o   = cmd_q;
    assign ex_wb_en_o     = wb_en_q;
    assign ex_mem_read_o  = mem_read_q;
    assign ex_mem_write_o = mem_write_q;
    assign ex_is_imm_o    = is_imm_q;
    assign bubble_cnt_o   = cnt_q;

endmodule
